// File: rtl/pipeline_control.sv
// pipeline_control: hazard arbitration for a five-stage pipeline.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   fw_if_id_stall          load-use stall request
//   ex_branch_taken         branch/jump resolved taken in Execute
//   mem_req, mem_ack        data access in progress / completed this cycle
//   pc_en .. mem_wb_en      load enables for PC and pipeline registers
//   if_id_flush             NOP into IF/ID
//   id_ex_bubble            NOP into ID/EX
//   ctrl_state              registered decision (RUN=0 LOADUSE=1 MEMWAIT=2 FLUSH=3)
//   stall_cycles            saturating count of freeze and load-use cycles
//   flush_count             saturating count of branch flushes
//   mem_timeout             sticky flag after MEM_TIMEOUT consecutive freeze cycles
module pipeline_control #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fw_if_id_stall,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout
);
   typedef enum logic [1:0] {RUN = 2'd0, LOADUSE = 2'd1, MEMWAIT = 2'd2, FLUSH = 2'd3} state_t;
   localparam int WT_W = MEM_TIMEOUT < 2 ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WT_W-1:0] WT_MAX = WT_W'(MEM_TIMEOUT);
   state_t state, next;
   logic [WT_W-1:0] wait_cnt, wait_next;
   // The decision is purely combinational; the state register only records it.
   // Outputs are gated by reset so they read 0 immediately on assertion.
   always_comb begin
      next = mem_req && !mem_ack ? MEMWAIT : ex_branch_taken ? FLUSH : fw_if_id_stall ? LOADUSE : RUN;
      wait_next = next != MEMWAIT ? '0 : wait_cnt == WT_MAX ? wait_cnt : wait_cnt + 1'b1;
      pc_en = !reset && (next == RUN || next == FLUSH);
      if_id_en = !reset && (next == RUN || next == FLUSH);
      id_ex_en = !reset && next != MEMWAIT;
      ex_mem_en = !reset && next != MEMWAIT;
      mem_wb_en = !reset && next != MEMWAIT;
      if_id_flush = !reset && next == FLUSH;
      id_ex_bubble = !reset && (next == FLUSH || next == LOADUSE);
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= RUN;
      else state <= next;
   assign ctrl_state = state;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         stall_cycles <= '0;
         flush_count <= '0;
         wait_cnt <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if ((next == LOADUSE || next == MEMWAIT) && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
         if (next == FLUSH && flush_count != '1) flush_count <= flush_count + 1'b1;
         wait_cnt <= wait_next;
         if (next == MEMWAIT && wait_next == WT_MAX) mem_timeout <= 1'b1;
      end
endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, number of consecutive memory-wait cycles before the timeout flag sets.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fw_if_id_stall  input  1  load-use stall request from the forwarding unit.
REQ-006 SHALL have port ex_branch_taken  input  1  branch or jump resolved taken in Execute.
REQ-007 SHALL have port mem_req  input  1  Memory stage is performing a data access.
REQ-008 SHALL have port mem_ack  input  1  data memory has completed the access this cycle.
REQ-009 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  load enables for PC and the pipeline registers.
REQ-010 SHALL have port if_id_flush  output  1  replace the IF/ID contents with a NOP.
REQ-011 SHALL have port id_ex_bubble  output  1  load a NOP into ID/EX.
REQ-012 SHALL have port ctrl_state  output  2  registered FSM state.
REQ-013 SHALL have port stall_cycles  output  CNT_W  count of freeze and load-use cycles.
REQ-014 SHALL have port flush_count  output  CNT_W  count of branch flushes.
REQ-015 SHALL have port mem_timeout  output  1  sticky memory-timeout flag.

Function
REQ-016 SHALL compute the control outputs combinationally from the current inputs, out of reset, using this priority order: FREEZE, then FLUSH, then LOADUSE, then RUN.
REQ-017 FREEZE (mem_req=1, mem_ack=0) SHALL drive all five enables to 0, if_id_flush=0 and id_ex_bubble=0, and SHALL ignore ex_branch_taken and fw_if_id_stall in that cycle.
REQ-018 FLUSH (ex_branch_taken=1, not FREEZE) SHALL drive all enables to 1, if_id_flush=1 and id_ex_bubble=1, and SHALL ignore fw_if_id_stall.
REQ-019 LOADUSE (fw_if_id_stall=1, no higher-priority condition) SHALL drive pc_en=0, if_id_en=0, id_ex_en=1, ex_mem_en=1, mem_wb_en=1, id_ex_bubble=1 and if_id_flush=0.
REQ-020 RUN (no condition active) SHALL drive all enables to 1, if_id_flush=0 and id_ex_bubble=0.
REQ-021 A held request SHALL keep the same response on every cycle it is held; there is no minimum or maximum duration.
REQ-022 ctrl_state SHALL register the decision of each cycle at the rising edge, encoded RUN=0, LOADUSE=1, MEMWAIT=2, FLUSH=3.
REQ-023 stall_cycles SHALL increment by 1 at each rising edge whose cycle was FREEZE or LOADUSE, and SHALL saturate at all-ones.
REQ-024 flush_count SHALL increment by 1 at each rising edge whose cycle was FLUSH, and SHALL saturate at all-ones.
REQ-025 An internal wait counter SHALL count consecutive FREEZE cycles, clear on any non-FREEZE cycle, and saturate at MEM_TIMEOUT.
REQ-026 mem_timeout SHALL set at the edge where the wait counter reaches MEM_TIMEOUT, and SHALL remain 1 until reset.
REQ-027 A timeout SHALL NOT alter the enables; FREEZE persists until mem_ack=1 or mem_req=0.
REQ-028 mem_req=1 with mem_ack=1 in the same cycle SHALL NOT be FREEZE; lower priorities SHALL then apply.

Reset
REQ-029 While reset=1: all enables SHALL be 0, if_id_flush=0, id_ex_bubble=0, ctrl_state=0, counters=0, mem_timeout=0 and the wait counter=0.
REQ-030 Reset SHALL take effect asynchronously, including mid-FREEZE; the first edge after release SHALL evaluate the inputs normally.

Verification
REQ-031 Scenario: fw_if_id_stall=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_bubble=1 that cycle; ctrl_state=1 next cycle, then 0; stall_cycles=1.
REQ-032 Scenario: ex_branch_taken=1 and fw_if_id_stall=1 together -> if_id_flush=1, id_ex_bubble=1, pc_en=1; flush_count=1; stall_cycles=0.
REQ-033 Scenario: mem_req=1, mem_ack=0 for 3 cycles, then ack, with ex_branch_taken=1 throughout -> 3 cycles of all enables 0; FLUSH on the 4th cycle; stall_cycles=3; flush_count=1.
REQ-034 Scenario: MEM_TIMEOUT=4, mem_req=1, mem_ack=0 for 6 cycles -> mem_timeout rises after the 4th edge, stays 1 after ack, and clears only on reset.
REQ-035 Scenario: CNT_W=4, 20 LOADUSE cycles -> stall_cycles holds at 15.
REQ-036 Scenario: reset asserted mid-FREEZE between clock edges -> all outputs 0 immediately; after release with idle inputs, all enables are 1.
